// File: rtl/alu_core.sv
// alu_core: single-cycle ALU with a registered result and flags.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   in_valid   srcA/srcB/ALUControl are qualified this cycle
//   srcA       operand A (32 bits)
//   srcB       operand B (32 bits); bits [4:0] give the shift amount for SLL
//   ALUControl operation select: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL
//   res        registered result
//   zero       registered, 1 when res == 0
//   negative   registered copy of res[31]
//   carry      registered carry (ADD) or no-borrow (SUB); 0 for other ops
//   overflow   registered signed overflow (ADD/SUB); 0 for other ops
//   out_valid  in_valid delayed by one cycle
//
// Result and flags are captured only when in_valid=1 and hold otherwise.
module alu_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic [2:0]  ALUControl,
   output logic [31:0] res,
   output logic        zero,
   output logic        negative,
   output logic        carry,
   output logic        overflow,
   output logic        out_valid
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SLT  = 3'b101,
      OP_SLTU = 3'b110,
      OP_SLL  = 3'b111
   } alu_op_t;

   alu_op_t     op;
   logic [32:0] sum33;
   logic [32:0] diff33;
   logic [31:0] res_c;
   logic        carry_c;
   logic        overflow_c;

   assign op = alu_op_t'(ALUControl);

   always_comb begin
      sum33      = {1'b0, srcA} + {1'b0, srcB};
      diff33     = {1'b0, srcA} - {1'b0, srcB};
      res_c      = '0;
      carry_c    = 1'b0;
      overflow_c = 1'b0;
      case (op)
         OP_ADD: begin
            res_c      = sum33[31:0];
            carry_c    = sum33[32];
            overflow_c = (srcA[31] == srcB[31]) && (sum33[31] != srcA[31]);
         end
         OP_SUB: begin
            res_c      = diff33[31:0];
            // bit 32 of the widened difference is the borrow
            carry_c    = ~diff33[32];
            overflow_c = (srcA[31] != srcB[31]) && (diff33[31] != srcA[31]);
         end
         OP_AND:  res_c = srcA & srcB;
         OP_OR:   res_c = srcA | srcB;
         OP_XOR:  res_c = srcA ^ srcB;
         // direct signed compare, so no subtract-overflow artefact at extremes
         OP_SLT:  res_c = {31'd0, ($signed(srcA) < $signed(srcB))};
         OP_SLTU: res_c = {31'd0, (srcA < srcB)};
         OP_SLL:  res_c = srcA << srcB[4:0];
         default: res_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res       <= '0;
         zero      <= 1'b1;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            res      <= res_c;
            zero     <= (res_c == '0);
            negative <= res_c[31];
            carry    <= carry_c;
            overflow <= overflow_c;
         end
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed plus randomized checks of alu_core against an
// arithmetic reference model (64-bit integer math, range tests for overflow).
module tb_alu_core;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [2:0]  ALUControl;
   logic [31:0] res;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_res;
   logic        exp_z, exp_n, exp_c, exp_v, exp_ov;

   alu_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .srcA       (srcA),
      .srcB       (srcB),
      .ALUControl (ALUControl),
      .res        (res),
      .zero       (zero),
      .negative   (negative),
      .carry      (carry),
      .overflow   (overflow),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".res"},       res,              exp_res);
      check({tag, ".zero"},      {31'd0, zero},     {31'd0, exp_z});
      check({tag, ".negative"},  {31'd0, negative}, {31'd0, exp_n});
      check({tag, ".carry"},     {31'd0, carry},    {31'd0, exp_c});
      check({tag, ".overflow"},  {31'd0, overflow}, {31'd0, exp_v});
      check({tag, ".out_valid"}, {31'd0, out_valid},{31'd0, exp_ov});
   endtask

   task automatic set_reset_expect();
      exp_res = '0; exp_z = 1'b1; exp_n = 1'b0; exp_c = 1'b0; exp_v = 1'b0; exp_ov = 1'b0;
   endtask

   // Reference: unsigned and signed values held as 64-bit integers.
   task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            output logic [31:0] r, output logic c, output logic v);
      longint ua, ub, sa, sb, t;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0: begin
            t = ua + ub;  r = t[31:0];  c = (t >= 64'sd4294967296);
            t = sa + sb;  v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         3'd1: begin
            t = ua - ub;  r = t[31:0];  c = (ua >= ub);
            t = sa - sb;  v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
         3'd6: r = (ua < ub) ? 32'd1 : 32'd0;
         default: begin
            t = ua * (64'sd1 << b[4:0]);
            r = t[31:0];
         end
      endcase
   endtask

   // Drive one cycle of input, advance past the edge, update model, check.
   task automatic step(input string tag, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        c, ov;
      in_valid = v; ALUControl = op; srcA = a; srcB = b;
      @(posedge clk); #1;
      if (v) begin
         ref_model(a, b, op, r, c, ov);
         exp_res = r; exp_z = (r == 32'd0); exp_n = r[31]; exp_c = c; exp_v = ov;
      end
      exp_ov = v;
      check_all(tag);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [31:0] sweep_exp [8];

   initial begin
      sweep_exp = '{32'h16, 32'hFFFF_FFFE, 32'h8, 32'hE, 32'h6, 32'h1, 32'h1, 32'hA000};
      rst_n = 1'b0; in_valid = 1'b0; srcA = '0; srcB = '0; ALUControl = '0;
      set_reset_expect();
      @(posedge clk); @(posedge clk); #1;
      check_all("reset");
      rst_n = 1'b1;

      // opcode sweep, back-to-back
      for (int unsigned i = 0; i < 8; i++) begin
         step("sweep", 1'b1, 3'(i), 32'd10, 32'd12);
         check("sweep.const", res, sweep_exp[i]);
         check("sweep.zero0", {31'd0, zero}, 32'd0);
      end

      step("sub_eq", 1'b1, 3'd1, 32'h1234, 32'h1234);
      check("sub_eq.z", {31'd0, zero, carry, overflow}, 32'b110);
      step("add_ovf", 1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1);
      check("add_ovf.c", {res[31:28], negative, carry, overflow}, {4'h8, 3'b101});
      step("add_wrap", 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1);
      check("add_wrap.c", {res[3:0], zero, carry, overflow}, {4'h0, 3'b110});
      step("slt_neg", 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1);
      check("slt_neg.r", res, 32'd1);
      step("sltu_neg", 1'b1, 3'd6, 32'hFFFF_FFFF, 32'd1);
      check("sltu_neg.z", {31'd0, zero}, 32'd1);
      step("slt_ext", 1'b1, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF);
      check("slt_ext.r", {res[30:0], overflow}, 32'd2);
      step("sll0", 1'b1, 3'd7, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
      check("sll0.r", res, 32'hDEAD_BEEF);
      step("sll31", 1'b1, 3'd7, 32'h0000_0003, 32'd31);
      check("sll31.r", res, 32'h8000_0000);

      // valid toggle 1,0,1: result held while invalid
      step("tog1", 1'b1, 3'd3, 32'h00F0, 32'h0F00);
      step("tog0", 1'b0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("tog0.hold", res, 32'h0FF0);
      step("tog1b", 1'b1, 3'd4, 32'hFF, 32'h0F);

      // asynchronous reset between edges with a capture pending
      in_valid = 1'b1; ALUControl = 3'd0; srcA = 32'd5; srcB = 32'd6;
      #2 rst_n = 1'b0;
      #1 set_reset_expect();
      check_all("rst_async");
      @(posedge clk); #1;
      check_all("rst_hold");
      rst_n = 1'b1;
      #1 check_all("rst_release");
      step("post_rst", 1'b1, 3'd0, 32'd5, 32'd6);
      check("post_rst.r", res, 32'd11);

      // randomized traffic
      for (int unsigned i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              pick_operand(), pick_operand());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clocks or resets.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operands and opcode qualified this cycle.
REQ-005 srcA  input  32  operand A.
REQ-006 srcB  input  32  operand B; bits [4:0] are the shift amount for shift ops.
REQ-007 ALUControl  input  3  operation select.
REQ-008 res  output  32  registered result.
REQ-009 zero  output  1  registered, 1 when res == 0.
REQ-010 negative  output  1  registered copy of res[31].
REQ-011 carry  output  1  registered carry or no-borrow flag.
REQ-012 overflow  output  1  registered signed-overflow flag.
REQ-013 out_valid  output  1  registered; outputs are valid this cycle.

Function
REQ-014 ALUControl encoding SHALL be:
- 000 ADD: A+B mod 2^32
- 001 SUB: A-B mod 2^32
- 010 AND
- 011 OR
- 100 XOR
- 101 SLT: signed A<B gives 1, else 0
- 110 SLTU: unsigned A<B gives 1, else 0
- 111 SLL: A << B[4:0], zero fill; B[31:5] ignored.
REQ-015 Result and flags SHALL be computed combinationally from the current inputs and captured on the rising clk edge when in_valid=1; latency is exactly 1 cycle.
REQ-016 When in_valid=0, res/zero/negative/carry/overflow SHALL hold their previous values, and out_valid SHALL be 0 on the next cycle.
REQ-017 out_valid SHALL equal in_valid delayed by one cycle; back-to-back valid inputs SHALL yield back-to-back results with no bubbles and no stall.
REQ-018 zero SHALL be 1 iff the registered res equals 0x00000000, for every op.
REQ-019 ADD: carry = bit 32 of the 33-bit unsigned sum; overflow = 1 when A and B have equal signs and the sum sign differs.
REQ-020 SUB: carry = 1 when A >= B unsigned (no borrow); overflow = 1 when A and B have different signs and the result sign differs from A.
REQ-021 AND, OR, XOR, SLT, SLTU, SLL: carry = 0 and overflow = 0.
REQ-022 SLT SHALL be correct at the extremes: A=0x80000000, B=0x7FFFFFFF gives res=1, with no overflow artefact.
REQ-023 SLL by 0 SHALL return A unchanged; SLL by 31 SHALL keep only A[0] in bit 31.

Reset
REQ-024 While rst_n=0, the block SHALL force res=0, zero=1, negative=0, carry=0, overflow=0 and out_valid=0 immediately, independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard any captured result; the first valid output after deassertion SHALL come from an in_valid sampled after rst_n rises.
REQ-026 Deassertion SHALL be treated as synchronous to clk; the first capture occurs on the first rising edge with rst_n=1.

Verification
REQ-027 Sweep with srcA=10, srcB=12, in_valid=1, ALUControl 0..7 -> res = 0x16, 0xFFFFFFFE, 0x8, 0xE, 0x6, 0x1, 0x1, 0xA000; zero=0 for all eight ops, each appearing one cycle after issue.
REQ-028 SUB with A=B=0x1234 -> res=0, zero=1, carry=1, overflow=0.
REQ-029 ADD 0x7FFFFFFF+1 -> res=0x80000000, overflow=1, negative=1, carry=0; ADD 0xFFFFFFFF+1 -> res=0, zero=1, carry=1, overflow=0.
REQ-030 SLT vs SLTU with A=0xFFFFFFFF, B=1 -> SLT res=1, SLTU res=0 with zero=1.
REQ-031 Assert rst_n=0 between clock edges after valid results -> all outputs go to reset values immediately; in_valid toggled 1,0,1 -> out_valid follows 1,0,1 one cycle later, with res held while invalid.
